// File: rtl/avalon_uart_readback.sv
// Purpose: reads word_cnt 32-bit words over Avalon-MM and streams each as four little-endian 8N1 UART bytes.
// Latency: first start bit one cycle after a read completes; done pulses two cycles after the final stop bit ends.
// Backpressure: avn_waitrequest stalls the read with address/read held; start is ignored until back in IDLE.
module avalon_uart_readback #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_cnt,
    input  logic [15:0]      cfg_div,
    output logic             avn_read,
    output logic             avn_write,
    output logic [31:0]      avn_address,
    output logic [3:0]       avn_byte_enable,
    output logic [31:0]      avn_writedata,
    input  logic [31:0]      avn_readdata,
    input  logic             avn_waitrequest,
    output logic             uart_txd,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        TX   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      word_q, word_d;
    logic [15:0]      div_cnt_q, div_cnt_d;
    logic [3:0]       bit_q, bit_d;     // 0 = start, 1..8 = data, 9 = stop
    logic [1:0]       byte_q, byte_d;   // byte lane of word_q being sent
    logic             done_q;

    logic [15:0]      div_eff;
    logic             bit_end;
    logic [7:0]       cur_byte;
    logic [3:0]       data_idx;
    logic             tx_bit;

    // A divider of zero behaves as one cycle per bit; cfg_div is used live, so
    // the >= compare keeps a shrinking divider from stalling the bit counter.
    always_comb begin
        div_eff  = (cfg_div == 16'd0) ? 16'd1 : cfg_div;
        bit_end  = (div_cnt_q >= (div_eff - 16'd1));
        cur_byte = word_q[{byte_q, 3'b000} +: 8];
        data_idx = bit_q - 4'd1;
    end

    // Serial bit for the current frame position.
    always_comb begin
        tx_bit = 1'b1;
        case (bit_q)
            4'd0:    tx_bit = 1'b0;
            4'd9:    tx_bit = 1'b1;
            default: tx_bit = cur_byte[data_idx[2:0]];
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            div_cnt_q <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            div_cnt_q <= div_cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
        end
    end

    // done is registered off the DONE state, so it lands the cycle after DONE
    // (two cycles after a zero-count start) while busy is already low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
        end
    end

    // Next-state logic: read one word, shift its four bytes out, advance.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        div_cnt_d = div_cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d    = {base_addr[31:2], 2'b00};
                    cnt_d     = word_cnt;
                    div_cnt_d = '0;
                    bit_d     = '0;
                    byte_d    = '0;
                    state_d   = (word_cnt == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (!avn_waitrequest) begin
                    word_d    = avn_readdata;
                    div_cnt_d = '0;
                    bit_d     = '0;
                    byte_d    = '0;
                    state_d   = TX;
                end
            end
            TX: begin
                if (bit_end) begin
                    div_cnt_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d = '0;
                        if (byte_q == 2'd3) begin
                            // Last stop bit of the word: step to the next word.
                            byte_d  = '0;
                            addr_d  = addr_q + 32'd4;
                            cnt_d   = cnt_q - CNT_W'(1);
                            state_d = (cnt_q == CNT_W'(1)) ? DONE : READ;
                        end else begin
                            byte_d = byte_q + 2'd1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign avn_read        = (state_q == READ);
    assign avn_address     = addr_q;
    assign avn_write       = 1'b0;
    assign avn_byte_enable = 4'hF;
    assign avn_writedata   = 32'h0;
    assign uart_txd        = (state_q == TX) ? tx_bit : 1'b1;
    assign busy            = (state_q == READ) || (state_q == TX);
    assign done            = done_q;

endmodule

// File: tb/tb_avalon_uart_readback.sv
// Purpose: directed bench for avalon_uart_readback with address/byte scoreboards and a UART frame decoder.
// Latency: done latency per run is predicted from word count, wait states and bit divider.
// Backpressure: a memory responder inserts a programmable number of waitrequest cycles per read.
module tb_avalon_uart_readback;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [31:0]      base_addr;
    logic [CNT_W-1:0] word_cnt;
    logic [15:0]      cfg_div;
    logic             avn_read;
    logic             avn_write;
    logic [31:0]      avn_address;
    logic [3:0]       avn_byte_enable;
    logic [31:0]      avn_writedata;
    logic [31:0]      avn_readdata;
    logic             avn_waitrequest;
    logic             uart_txd;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_byte_q[$];

    int div_eff     = 1;
    int wait_cycles = 0;
    int exp_rd_len  = 1;
    int wcnt        = 0;

    avalon_uart_readback #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .base_addr       (base_addr),
        .word_cnt        (word_cnt),
        .cfg_div         (cfg_div),
        .avn_read        (avn_read),
        .avn_write       (avn_write),
        .avn_address     (avn_address),
        .avn_byte_enable (avn_byte_enable),
        .avn_writedata   (avn_writedata),
        .avn_readdata    (avn_readdata),
        .avn_waitrequest (avn_waitrequest),
        .uart_txd        (uart_txd),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hA1B2_C3D4;
        return (a * 32'h9E37_79B9) ^ 32'h0F1E_2D3C;
    endfunction

    // Memory responder: waitrequest for wait_cycles cycles of each read, junk data until accepted.
    assign avn_waitrequest = avn_read && (wcnt < wait_cycles);
    assign avn_readdata    = avn_waitrequest ? 32'hDEAD_BEEF : data_of(avn_address);

    always @(posedge clk) begin
        if (avn_read && avn_waitrequest) wcnt <= wcnt + 1;
        else                             wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Avalon monitor: address scoreboard, hold-under-wait, read length, idle line while reading.
    initial begin : rd_mon
        logic        prev_wait;
        logic [31:0] prev_addr;
        logic [31:0] ea;
        int          len;
        prev_wait = 1'b0;
        prev_addr = '0;
        len       = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_wait = 1'b0;
                len       = 0;
            end else begin
                if (prev_wait) begin
                    chk("rd_hold_read", {31'b0, avn_read}, 32'h1);
                    chk("rd_hold_addr", avn_address, prev_addr);
                end
                if (avn_read === 1'b1) begin
                    chk("txd_idle_in_read", {31'b0, uart_txd}, 32'h1);
                    len++;
                    if (avn_waitrequest === 1'b0) begin
                        checks++;
                        assert (exp_addr_q.size() != 0) else begin
                            errors++;
                            $error("FAIL unexpected_read: observed addr %h expected no read", avn_address);
                        end
                        if (exp_addr_q.size() != 0) begin
                            ea = exp_addr_q.pop_front();
                            chk("rd_addr", avn_address, ea);
                            chk("rd_len", len, exp_rd_len);
                        end
                        len = 0;
                    end
                end
                prev_wait = (avn_read === 1'b1) && (avn_waitrequest === 1'b1);
                prev_addr = avn_address;
            end
        end
    end

    // UART decoder: every cycle of each bit must hold its level; stop bit must be 1.
    initial begin : uart_rx
        logic [9:0] bits;
        logic       s;
        logic       glitch;
        logic       aborted;
        logic [7:0] eb;
        int         d;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_txd === 1'b0) begin
                d       = div_eff;
                glitch  = 1'b0;
                aborted = 1'b0;
                bits    = '0;
                for (int k = 0; k < 10 && !aborted; k++) begin
                    for (int j = 0; j < d && !aborted; j++) begin
                        if (k != 0 || j != 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                        end else begin
                            s = uart_txd;
                            if (j == 0) bits[k] = s;
                            else if (s !== bits[k]) glitch = 1'b1;
                        end
                    end
                end
                if (!aborted) begin
                    chk("frame_glitch_stop", {30'b0, glitch, bits[9]}, 32'h1);
                    checks++;
                    assert (exp_byte_q.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_byte: observed %h expected no UART byte", bits[8:1]);
                    end
                    if (exp_byte_q.size() != 0) begin
                        eb = exp_byte_q.pop_front();
                        chk("uart_byte", {24'b0, bits[8:1]}, {24'b0, eb});
                    end
                end
            end
        end
    end

    task automatic push_expect(input logic [31:0] base, input int cnt);
        logic [31:0] a;
        logic [31:0] w;
        a = {base[31:2], 2'b00};
        for (int i = 0; i < cnt; i++) begin
            exp_addr_q.push_back(a);
            w = data_of(a);
            for (int b = 0; b < 4; b++) exp_byte_q.push_back(w[8*b +: 8]);
            a = a + 32'd4;
        end
    endtask

    task automatic run(input logic [31:0] base, input int cnt, input logic [15:0] div,
                       input int nwait, input bit poke);
        int idx;
        int lows;
        int exp_idx;
        bit seen;
        push_expect(base, cnt);
        div_eff     = (div == 16'd0) ? 1 : int'(div);
        wait_cycles = nwait;
        exp_rd_len  = nwait + 1;
        base_addr   = base;
        word_cnt    = CNT_W'(cnt);
        cfg_div     = div;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        idx     = 0;
        lows    = 0;
        seen    = 1'b0;
        exp_idx = cnt * (1 + nwait + 40 * div_eff) + 2;
        for (int n = 1; n <= exp_idx + 20 && !seen; n++) begin
            @(negedge clk);
            if (poke && n == 10) begin
                start     = 1'b1;
                base_addr = 32'hDEAD_0000;
                word_cnt  = CNT_W'(7);
            end
            if (poke && n == 11) start = 1'b0;
            if (busy !== 1'b1) lows++;
            if (done === 1'b1) begin
                seen = 1'b1;
                idx  = n;
            end
        end
        chk("done_seen", {31'b0, seen}, 32'h1);
        chk("done_latency", idx, exp_idx);
        chk("busy_low_cycles", lows, 2);
        @(negedge clk);
        chk("done_width", {31'b0, done}, 32'h0);
        chk("rd_sb_empty", exp_addr_q.size(), 0);
        chk("byte_sb_empty", exp_byte_q.size(), 0);
    endtask

    initial begin : stim
        logic [31:0] w;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        word_cnt  = '0;
        cfg_div   = 16'd4;
        #1;
        chk("rst_read", {31'b0, avn_read}, 32'h0);
        chk("rst_txd", {31'b0, uart_txd}, 32'h1);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_addr", avn_address, 32'h0);
        chk("const_write", {31'b0, avn_write}, 32'h0);
        chk("const_be", {28'b0, avn_byte_enable}, 32'hF);
        chk("const_wdata", avn_writedata, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, zero wait: bytes D4 C3 B2 A1 at 40 cycles each.
        run(32'h0000_0100, 1, 16'd4, 0, 1'b0);
        // Three words across the 32-bit wrap; low address bits ignored.
        run(32'hFFFF_FFFB, 3, 16'd2, 0, 1'b0);
        // Five waitrequest cycles per read.
        run(32'h0000_0040, 1, 16'd3, 5, 1'b0);
        // Zero words: no read, no UART, done two cycles after start.
        run(32'h0000_0080, 0, 16'd4, 0, 1'b0);
        // Start and base_addr poked mid-run; cfg_div=0 acts as one cycle per bit.
        run(32'h0000_0300, 2, 16'd0, 1, 1'b1);

        // Reset during the second data bit of byte 1.
        w = data_of(32'h0000_0200);
        push_expect(32'h0000_0200, 1);
        div_eff     = 4;
        wait_cycles = 0;
        exp_rd_len  = 1;
        base_addr   = 32'h0000_0200;
        word_cnt    = CNT_W'(1);
        cfg_div     = 16'd4;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 51; n++) @(negedge clk);
        chk("pre_reset_txd", {31'b0, uart_txd}, {31'b0, w[9]});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", {31'b0, uart_txd}, 32'h1);
        chk("mid_rst_read", {31'b0, avn_read}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        chk("mid_rst_addr", avn_address, 32'h0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("rst_no_done", {31'b0, done}, 32'h0);
        end
        rst_n = 1'b1;
        exp_addr_q.delete();
        exp_byte_q.delete();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("post_rst_idle", {29'b0, done, busy, uart_txd}, 32'h1);
        end
        run(32'h0000_0500, 1, 16'd2, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
